race_arbiter: RTL and testbench
===============================

// Module: race_arbiter
//
// PURPOSE
//   Shares one race_observer (start/done handshake) among N_REQ requesters.
//   Each requester runs a 4-phase req/ack handshake. The arbiter grants one
//   requester at a time in round-robin order and drives the observer's start.
//   It returns ack when the observer raises done, then releases the observer
//   before serving the next requester. Sits between racer front-ends and one
//   observer instance.
//
// PARAMETERS
//   N_REQ    4    number of requesters (2..8)
//   ID_W     2    width of grant_id; must be >= clog2(N_REQ)
//   TIMEOUT  255  max RUN-state cycles waiting for obs_done (TIMEOUT_EN only)
//
// PORTS
//   clk        in   1      single clock; all logic on posedge
//   rst        in   1      synchronous, active-high reset
//   req        in   N_REQ  per-requester request level
//   ack        out  N_REQ  per-requester acknowledge level (one-hot or zero)
//   obs_start  out  1      start to the shared observer
//   obs_done   in   1      done from the shared observer
//   busy       out  1      high in every state except IDLE
//   grant_id   out  ID_W   index of the current or last granted requester
//   timed_out  out  1      qualifies ack as a failed race (TIMEOUT_EN only, else 0)
//
// BEHAVIOUR
//   - All outputs are registered.
//   - Reset (rst=1 at posedge) sets:
//     - state=IDLE, ack=0, obs_start=0, busy=0, grant_id=0, timed_out=0
//     - rr_last=N_REQ-1, so requester 0 has first priority.
//     - Reset mid-operation aborts at once: obs_start drops, no ack is issued.
//   - State IDLE:
//     - When req!=0, pick the first set bit scanning rr_last+1, rr_last+2, ...
//       with modulo-N_REQ wrap.
//     - Next cycle: grant_id=winner, obs_start=1, busy=1, state=RUN.
//     - Latency: 1 cycle from req to obs_start.
//   - State RUN:
//     - obs_done=1 -> ack[grant_id]<=1 and state=ACK. obs_start stays 1,
//       because the observer holds done only while start is high.
//     - req[grant_id]=0 before done (abandon) -> obs_start<=0, state=DRAIN,
//       no ack.
//     - Abandon and obs_done in the same cycle: abandon wins.
//   - State ACK:
//     - Wait for req[grant_id]=0.
//     - Then ack<=0, obs_start<=0, timed_out<=0, state=DRAIN.
//   - State DRAIN:
//     - Wait for obs_done=0, which the observer clears 1 cycle after start drops.
//     - Then rr_last<=grant_id, busy<=0, state=IDLE.
//     - Guarantees obs_start never re-rises while done is still high.
//   - Fairness:
//     - A winner is never re-granted while another req bit was set at that
//       winner's IDLE decision.
//     - req changes of non-granted requesters are ignored outside IDLE.
//   - Illegal or unused state encodings return to IDLE with all outputs
//     cleared.
//   - Minimum per-request turnaround: 5 cycles (IDLE, RUN, ACK, DRAIN, IDLE).
//
// CONFIGURATION
//   - Macro RACE_ARBITER_TIMEOUT_EN:
//     - Defined:
//       - An 8-bit (clog2(TIMEOUT+1)) counter clears on RUN entry and
//         increments every RUN cycle.
//       - If it reaches TIMEOUT with obs_done=0: obs_start<=0,
//         ack[grant_id]<=1, timed_out<=1, state=ACK.
//       - The requester sees ack+timed_out as a failed race.
//       - The ACK/DRAIN exit is unchanged.
//       - obs_done arriving on the same cycle as the timeout wins:
//         normal ack, timed_out=0.
//     - Undefined: no counter, timed_out tied 0, RUN waits indefinitely.
//
// TESTING
//   1. Reset: hold rst=1 for 3 cycles with req=4'b1111
//      -> ack=0, obs_start=0, busy=0, grant_id=0 throughout.
//   2. Single request: req=4'b0100; observer done 6 cycles after start
//      -> obs_start at +1; ack[2] the cycle after done; drop req -> ack
//      and obs_start clear next cycle; busy clears once done=0.
//   3. Round-robin: req=4'b1111 held, each requester drops after its ack
//      then re-raises -> grant order 0,1,2,3,0; no double grant.
//   4. Abandon: req[1] falls 2 cycles after obs_start=1
//      -> obs_start=0 next cycle, ack stays 0, DRAIN then IDLE, rr_last=1.
//   5. Reset mid-ACK: rst=1 while ack[3]=1
//      -> next cycle ack=0, obs_start=0, IDLE; req[0] is served first after
//      reset.
//   6. TIMEOUT_EN, TIMEOUT=10, observer done held 0
//      -> obs_start drops after 10 RUN cycles, ack[grant] and timed_out rise
//      together, both clear after req drops.

Source files
------------

// File: rtl/race_arbiter.sv
// Round-robin arbiter sharing one start/done observer among N_REQ 4-phase requesters.
// Optional RUN-state timeout enabled by defining RACE_ARBITER_TIMEOUT_EN.
module race_arbiter #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned ID_W    = 2,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] ack,
  output logic             obs_start,
  input  logic             obs_done,
  output logic             busy,
  output logic [ID_W-1:0]  grant_id,
  output logic             timed_out
);

  typedef enum logic [1:0] {IDLE, RUN, ACK, DRAIN} state_t;

  state_t          state;
  logic [ID_W-1:0] rr_last;
  logic [ID_W-1:0] winner;
  logic [ID_W-1:0] low_id;
  logic [ID_W-1:0] high_id;
  logic            low_found;
  logic            high_found;

`ifdef RACE_ARBITER_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt;
`endif

  // Round-robin: the lowest set bit above rr_last wins, else wrap to the lowest set bit.
  always_comb begin
    low_id     = '0;
    high_id    = '0;
    low_found  = 1'b0;
    high_found = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (req[i] && !low_found) begin
        low_id    = ID_W'(i);
        low_found = 1'b1;
      end
      if (req[i] && !high_found && (i > 32'(rr_last))) begin
        high_id    = ID_W'(i);
        high_found = 1'b1;
      end
    end
    winner = high_found ? high_id : low_id;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ack       <= '0;
      obs_start <= 1'b0;
      busy      <= 1'b0;
      grant_id  <= '0;
      timed_out <= 1'b0;
      rr_last   <= ID_W'(N_REQ - 1);
`ifdef RACE_ARBITER_TIMEOUT_EN
      cnt       <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req != '0) begin
            grant_id  <= winner;
            obs_start <= 1'b1;
            busy      <= 1'b1;
            state     <= RUN;
`ifdef RACE_ARBITER_TIMEOUT_EN
            cnt       <= '0;
`endif
          end
        end
        RUN: begin
          // Abandon beats done; done beats timeout.
          if (!req[grant_id]) begin
            obs_start <= 1'b0;
            state     <= DRAIN;
          end else if (obs_done) begin
            ack   <= N_REQ'(1) << grant_id;
            state <= ACK;
          end
`ifdef RACE_ARBITER_TIMEOUT_EN
          else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            obs_start <= 1'b0;
            ack       <= N_REQ'(1) << grant_id;
            timed_out <= 1'b1;
            state     <= ACK;
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        ACK: begin
          if (!req[grant_id]) begin
            ack       <= '0;
            obs_start <= 1'b0;
            timed_out <= 1'b0;
            state     <= DRAIN;
          end
        end
        DRAIN: begin
          if (!obs_done) begin
            rr_last <= grant_id;
            busy    <= 1'b0;
            state   <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          ack       <= '0;
          obs_start <= 1'b0;
          busy      <= 1'b0;
          timed_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_race_arbiter.sv
// Directed self-checking bench for race_arbiter with a behavioural observer model.
// Timeout scenario is exercised when RACE_ARBITER_TIMEOUT_EN is defined.
module tb_race_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b1111;
  logic [3:0] ack;
  logic       obs_start;
  logic       obs_done = 1'b0;
  logic       busy;
  logic [1:0] grant_id;
  logic       timed_out;

  int checks = 0;
  int errors = 0;
  int obs_delay = 6;
  bit obs_stuck = 1'b0;
  int ocnt = 0;
  int order [5] = '{0, 1, 2, 3, 0};

  race_arbiter #(.N_REQ(4), .ID_W(2), .TIMEOUT(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .ack       (ack),
    .obs_start (obs_start),
    .obs_done  (obs_done),
    .busy      (busy),
    .grant_id  (grant_id),
    .timed_out (timed_out)
  );

  always #5 clk = ~clk;

  // Observer: raises done obs_delay cycles after start, holds it while start is high,
  // clears it one cycle after start drops.
  always @(posedge clk) begin
    if (!obs_start) begin
      obs_done <= 1'b0;
      ocnt     <= 0;
    end else begin
      ocnt <= ocnt + 1;
      if (!obs_stuck && (ocnt + 1 >= obs_delay)) obs_done <= 1'b1;
    end
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic bit cond(input int sel);
    case (sel)
      0:       return obs_start === 1'b1;
      1:       return ack !== 4'b0000;
      2:       return busy === 1'b0;
      default: return obs_done === 1'b1;
    endcase
  endfunction

  task automatic wait_until(input int sel, input string tag);
    int n = 0;
    while (!cond(sel) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(tag, (n < 100) ? 32'd1 : 32'd0, 32'd1);
  endtask

  initial begin
    // Reset held with all requests asserted
    for (int unsigned i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_ack", 32'(ack), 32'h0);
      check("rst_start", 32'(obs_start), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_gid", 32'(grant_id), 32'h0);
    end
    rst = 1'b0;
    req = 4'b0000;
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'h0);

    // Single request on requester 2
    req = 4'b0100;
    @(negedge clk);
    check("t2_start", 32'(obs_start), 32'h1);
    check("t2_gid", 32'(grant_id), 32'h2);
    check("t2_busy", 32'(busy), 32'h1);
    wait_until(3, "t2_done_wait");
    check("t2_ack_pre", 32'(ack), 32'h0);
    @(negedge clk);
    check("t2_ack", 32'(ack), 32'h4);
    check("t2_start_hold", 32'(obs_start), 32'h1);
    check("t2_to", 32'(timed_out), 32'h0);
    req = 4'b0000;
    @(negedge clk);
    check("t2_ack_clr", 32'(ack), 32'h0);
    check("t2_start_clr", 32'(obs_start), 32'h0);
    check("t2_busy_drain", 32'(busy), 32'h1);
    @(negedge clk);
    check("t2_busy_done_hi", 32'(busy), 32'h1);
    @(negedge clk);
    check("t2_busy_clr", 32'(busy), 32'h0);

    // Round-robin with all requesters; reset first so requester 0 leads
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    obs_delay = 2;
    req = 4'b1111;
    for (int unsigned k = 0; k < 5; k++) begin
      wait_until(0, "t3_start_wait");
      check("t3_gid", 32'(grant_id), 32'(order[k]));
      wait_until(1, "t3_ack_wait");
      check("t3_ack", 32'(ack), 32'h1 << order[k]);
      if (k == 4) req = 4'b0000;
      else        req[order[k]] = 1'b0;
      wait_until(2, "t3_idle_wait");
      if (k < 4) req[order[k]] = 1'b1;
    end

    // Abandon by requester 1
    obs_delay = 20;
    req = 4'b0010;
    @(negedge clk);
    check("t4_start", 32'(obs_start), 32'h1);
    check("t4_gid", 32'(grant_id), 32'h1);
    @(negedge clk);
    @(negedge clk);
    req = 4'b0000;
    @(negedge clk);
    check("t4_start_clr", 32'(obs_start), 32'h0);
    check("t4_no_ack", 32'(ack), 32'h0);
    check("t4_busy_drain", 32'(busy), 32'h1);
    @(negedge clk);
    check("t4_busy_clr", 32'(busy), 32'h0);
    req = 4'b1111;
    @(negedge clk);
    check("t4_rr_next", 32'(grant_id), 32'h2);

    // Requester 2 abandons, 3 is granted and reaches ACK, then reset
    obs_delay = 3;
    req = 4'b1000;
    wait_until(1, "t5_ack_wait");
    check("t5_ack3", 32'(ack), 32'h8);
    rst = 1'b1;
    req = 4'b1111;
    @(negedge clk);
    check("t5_ack_rst", 32'(ack), 32'h0);
    check("t5_start_rst", 32'(obs_start), 32'h0);
    check("t5_busy_rst", 32'(busy), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check("t5_start_after", 32'(obs_start), 32'h1);
    check("t5_gid_after", 32'(grant_id), 32'h0);
    req = 4'b0000;
    wait_until(2, "t5_idle_wait");

    // Observer never completes
    obs_stuck = 1'b1;
    req = 4'b0001;
`ifdef RACE_ARBITER_TIMEOUT_EN
    repeat (10) @(negedge clk);
    check("t6_start_run", 32'(obs_start), 32'h1);
    check("t6_ack_run", 32'(ack), 32'h0);
    @(negedge clk);
    check("t6_start_to", 32'(obs_start), 32'h0);
    check("t6_ack_to", 32'(ack), 32'h1);
    check("t6_to", 32'(timed_out), 32'h1);
    req = 4'b0000;
    @(negedge clk);
    check("t6_ack_clr", 32'(ack), 32'h0);
    check("t6_to_clr", 32'(timed_out), 32'h0);
`else
    repeat (15) @(negedge clk);
    check("t6_start_wait", 32'(obs_start), 32'h1);
    check("t6_no_ack", 32'(ack), 32'h0);
    check("t6_to_zero", 32'(timed_out), 32'h0);
    req = 4'b0000;
`endif
    wait_until(2, "t6_idle_wait");
    obs_stuck = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
